// File: rtl/booth_pkg.sv
// ============================================================================
// Module : booth_pkg
// Brief  : Shared state encoding and default widths for booth_mult_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    localparam int c_N = 4;
    localparam int c_W = 8;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = c_IDLE,
        RUN     = c_RUN,
        RELEASE = c_RELEASE,
        RESP    = c_RESP
    } state_t;

endpackage

`default_nettype wire

// File: rtl/booth_mult_arbiter_if.sv
// ============================================================================
// Module : booth_mult_arbiter_if
// Brief  : Request/response channels and multiplier start/done bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_mult_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [2*W-1:0] rsp_product;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_product;
    logic           busy;

    // Clients and the multiplier live on the master side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
        input  req_ready, rsp_valid, rsp_product, mul_start, mul_a, mul_b, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
        output req_ready, rsp_valid, rsp_product, mul_start, mul_a, mul_b, busy
    );
endinterface

`default_nettype wire

// File: rtl/booth_mult_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin pick: lowest requester at or above ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [PW-1:0] ptr,
    output logic      [N-1:0]  gnt,
    output logic      [PW-1:0] idx
);

    logic [PW:0] w_sum;
    logic        w_found;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < N; i++) begin
            // ptr + i stays below 2N, so one conditional subtract is a full modulo.
            w_sum = {1'b0, ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            if (!w_found && req[w_sum[PW-1:0]]) begin
                w_found             = 1'b1;
                idx                 = w_sum[PW-1:0];
                gnt[w_sum[PW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/booth_mult_arbiter.sv
// ============================================================================
// Module : booth_mult_arbiter
// Brief  : Round-robin sharing of one Booth multiplier among N requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter int N = c_N,
    parameter int W = c_W
) (
    input  wire logic            clk,
    input  wire logic            rst,
    booth_mult_arbiter_if.slave  bus
);

    localparam int c_PW = $clog2(N);

    state_t           r_state_q, w_state_d;
    logic [c_PW-1:0]  r_ptr_q,   w_ptr_d;
    logic [c_PW-1:0]  r_op_id_q, w_op_id_d;
    logic [W-1:0]     r_op_a_q,  w_op_a_d;
    logic [W-1:0]     r_op_b_q,  w_op_b_d;
    logic [2*W-1:0]   r_res_q,   w_res_d;

    logic [N-1:0]     w_gnt;
    logic [c_PW-1:0]  w_idx;
    logic [N-1:0]     w_req_ready;
    logic [N-1:0]     w_rsp_valid;
    logic             w_mul_start;

    rr_pick #(
        .N  (N),
        .PW (c_PW)
    ) u_rr_pick (
        .req (bus.req_valid),
        .ptr (r_ptr_q),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_op_id_d   = r_op_id_q;
        w_op_a_d    = r_op_a_q;
        w_op_b_d    = r_op_b_q;
        w_res_d     = r_res_q;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_mul_start = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (bus.req_valid != '0) begin
                    w_req_ready = w_gnt;
                    w_op_id_d   = w_idx;
                    w_op_a_d    = bus.req_a[int'(w_idx)*W +: W];
                    w_op_b_d    = bus.req_b[int'(w_idx)*W +: W];
                    w_ptr_d     = (w_idx == c_PW'(N-1)) ? '0 : w_idx + c_PW'(1);
                    w_state_d   = RUN;
                end
            end
            RUN: begin
                w_mul_start = 1'b1;
                if (bus.mul_done) begin
                    w_res_d   = bus.mul_product;
                    w_state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for the multiplier to leave DONE so a later start is seen fresh.
                if (!bus.mul_done) begin
                    w_state_d = RESP;
                end
            end
            RESP: begin
                w_rsp_valid[r_op_id_q] = 1'b1;
                if (bus.rsp_ready[r_op_id_q]) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_ptr_q   <= '0;
            r_op_id_q <= '0;
            r_op_a_q  <= '0;
            r_op_b_q  <= '0;
            r_res_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_op_id_q <= w_op_id_d;
            r_op_a_q  <= w_op_a_d;
            r_op_b_q  <= w_op_b_d;
            r_res_q   <= w_res_d;
        end
    end

    // Operand and result registers only change on entry to RUN/RELEASE,
    // so they hold their values everywhere else.
    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.mul_start   = w_mul_start;
    assign bus.mul_a       = r_op_a_q;
    assign bus.mul_b       = r_op_b_q;
    assign bus.rsp_product = r_res_q;
    assign bus.busy        = (r_state_q != IDLE);

endmodule

`default_nettype wire
